// File: rtl/soc_intc_pkg.sv
// Shared encodings for the SoC interrupt controller: FSM states, register
// offsets and the fixed source index assignment.
package soc_intc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SVC  = 2'b10
  } intc_state_e;

  localparam logic [1:0] REG_MASK   = 2'd0;
  localparam logic [1:0] REG_PEND   = 2'd1;
  localparam logic [1:0] REG_ACTIVE = 2'd2;
  localparam logic [1:0] REG_GLOBAL = 2'd3;

  localparam int SRC_FACCEL = 0;
  localparam int SRC_FPM    = 1;

endpackage

// File: rtl/soc_int_ctrl_if.sv
// Bus bundle between the SoC (register decode, accelerators, MIPS core) and
// the interrupt controller.
interface soc_int_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 3
);
  logic [NUM_SRC-1:0] src_done;
  logic               we;
  logic [1:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic               int_ack;
  logic               int_eoi;

  modport master (
    output src_done, we, addr, wdata, int_ack, int_eoi,
    input  rdata, irq, irq_id
  );

  modport slave (
    input  src_done, we, addr, wdata, int_ack, int_eoi,
    output rdata, irq, irq_id
  );
endinterface

// File: rtl/intc_prio_arb.sv
// Combinational picker: first set request found searching upward from start_i,
// wrapping modulo NUM_SRC. start_i = 0 gives fixed lowest-index priority.
module intc_prio_arb #(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    winner_o
);

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!valid_o && req_i[i] && (((int'(start_i) + k) % NUM_SRC) == i)) begin
          valid_o  = 1'b1;
          winner_o = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/soc_int_ctrl.sv
// Memory-mapped interrupt controller: edge-detected sources, mask/pending
// registers, single arbitrated irq with ack/EOI handshake to the core.
// Define INTC_ROUND_ROBIN_EN for rotating priority (default: fixed, lowest index).
module soc_int_ctrl
  import soc_intc_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 3
) (
  input  logic          clk,
  input  logic          reset,
  soc_int_ctrl_if.slave bus
);

  intc_state_e        state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               glb_q, glb_d;

  logic [NUM_SRC-1:0] evt, req, clr, id_onehot;
  logic               ack_fire;
  logic               arb_valid;
  logic [ID_W-1:0]    arb_winner;
  logic [ID_W-1:0]    arb_start;
  logic               unused_wdata;

  assign unused_wdata = ^bus.wdata[31:NUM_SRC];

  assign evt      = bus.src_done & ~src_q;
  assign req      = glb_q ? (pend_q & mask_q) : '0;
  assign ack_fire = (state_q == REQ) && bus.int_ack;

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) id_onehot[i] = (id_q == ID_W'(i));
  end

`ifdef INTC_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ptr_q <= '0;
    else if (ack_fire) ptr_q <= id_q;
  end

  assign arb_start = (ptr_q == ID_W'(NUM_SRC - 1)) ? '0 : ptr_q + 1'b1;
`else
  assign arb_start = '0;
`endif

  intc_prio_arb #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_arb (
    .req_i    (req),
    .start_i  (arb_start),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  // Event OR-ed in last so a new edge survives a same-cycle clear.
  always_comb begin
    mask_d = mask_q;
    glb_d  = glb_q;
    clr    = '0;
    if (bus.we) begin
      case (bus.addr)
        REG_MASK:   mask_d = bus.wdata[NUM_SRC-1:0];
        REG_PEND:   clr    = bus.wdata[NUM_SRC-1:0];
        REG_GLOBAL: glb_d  = bus.wdata[0];
        default:    ;
      endcase
    end
    if (ack_fire) clr = clr | id_onehot;
    pend_d = (pend_q & ~clr) | evt;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = REQ;
          id_d    = arb_winner;
        end
      end
      REQ: begin
        if (bus.int_ack)                 state_d = SVC;
        else if ((req & id_onehot) == '0) state_d = IDLE;
      end
      SVC: begin
        if (bus.int_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      glb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      src_q   <= bus.src_done;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      glb_q   <= glb_d;
    end
  end

  assign bus.irq    = (state_q == REQ);
  assign bus.irq_id = id_q;

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      REG_MASK:   bus.rdata[NUM_SRC-1:0] = mask_q;
      REG_PEND:   bus.rdata[NUM_SRC-1:0] = pend_q;
      REG_ACTIVE: begin
        bus.rdata[9:8]      = state_q;
        bus.rdata[ID_W-1:0] = id_q;
      end
      REG_GLOBAL: bus.rdata[0] = glb_q;
      default:    ;
    endcase
  end

endmodule
